// File: rtl/hid_cmd_parser.sv
// -----------------------------------------------------------------------------
// hid_cmd_parser
//
// Frame parser and command sequencer placed behind the UART receiver.
// Frame format: SYNC, OP, LEN, LEN payload bytes, CSUM.
// CSUM is the XOR of OP, LEN and all payload bytes. SYNC is not included.
// A validated frame is loaded into a held output register and offered with a
// valid/ready handshake. Framing errors are reported as coded one-cycle
// strobes. An inter-byte timeout drops a partial frame.
//
// Ports
//   clk          : system clock. Everything is on the rising edge.
//   reset        : asynchronous reset, active low.
//   rx_valid     : one-cycle byte strobe from the UART receiver.
//   rx_byte      : received byte. It is valid while rx_valid is high.
//   cmd_valid    : a validated command is held on the cmd_* outputs.
//   cmd_ready    : the consumer accepts the held command.
//   cmd_op       : command opcode.
//   cmd_len      : payload length, 0..MAX_LEN.
//   cmd_payload  : payload bytes. The first byte is in [7:0]. Unused bytes are 0.
//   err_valid    : one-cycle error strobe.
//   err_code     : 01 length over MAX_LEN, 10 checksum, 11 timeout.
//                  It holds its value between strobes.
//   drop         : one-cycle strobe. It fires when a good frame is lost
//                  because the output register is still held.
// -----------------------------------------------------------------------------
module hid_cmd_parser #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter int unsigned MAX_LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic        drop
);

  localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_FREQ / 1000000) * TIMEOUT_US);
  localparam logic [7:0]  MAX_LEN_B      = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  state_t      r_state;
  logic [7:0]  r_op;
  logic [2:0]  r_len;
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;
  logic [31:0] r_pay;
  logic [31:0] r_tcnt;

  logic        w_timeout;
  logic        w_last_pay;

  // A byte arriving on the terminal-count cycle wins over the timeout.
  assign w_timeout  = (r_state != S_IDLE) && !rx_valid &&
                      (r_tcnt == TIMEOUT_CYCLES - 32'd1);
  assign w_last_pay = ({1'b0, r_idx} == (r_len - 3'd1));

  // NOTE: every register below is updated with non-blocking assignments.
  // Later assignments in the block override the default clears at the top,
  // and all right-hand sides read the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_csum      <= '0;
      r_pay       <= '0;
      r_tcnt      <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
      drop        <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      drop      <= 1'b0;

      // The consumer takes the held command. A commit further down can set
      // cmd_valid again in the same cycle.
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (rx_valid || r_state == S_IDLE) r_tcnt <= '0;
      else                               r_tcnt <= r_tcnt + 32'd1;

      if (w_timeout) begin
        err_valid <= 1'b1;
        err_code  <= 2'b11;
        r_state   <= S_IDLE;
      end else if (rx_valid) begin
        unique case (r_state)
          S_IDLE: begin
            if (rx_byte == SYNC_BYTE) begin
              r_state <= S_OP;
              r_pay   <= '0;  // unused payload slots must read back as zero
              r_idx   <= '0;
            end
          end
          S_OP: begin
            r_op    <= rx_byte;
            r_csum  <= rx_byte;
            r_state <= S_LEN;
          end
          S_LEN: begin
            if (rx_byte > MAX_LEN_B) begin
              err_valid <= 1'b1;
              err_code  <= 2'b01;
              r_state   <= S_IDLE;
            end else begin
              r_len   <= rx_byte[2:0];
              r_csum  <= r_csum ^ rx_byte;
              r_state <= (rx_byte == 8'd0) ? S_CSUM : S_PAY;
            end
          end
          S_PAY: begin
            r_pay[{r_idx, 3'b000} +: 8] <= rx_byte;
            r_csum                      <= r_csum ^ rx_byte;
            r_idx                       <= r_idx + 2'd1;
            if (w_last_pay) r_state <= S_CSUM;
          end
          S_CSUM: begin
            r_state <= S_IDLE;
            if (rx_byte == r_csum) begin
              if (!cmd_valid || cmd_ready) begin
                cmd_valid   <= 1'b1;
                cmd_op      <= r_op;
                cmd_len     <= r_len;
                cmd_payload <= r_pay;
              end else begin
                drop <= 1'b1;
              end
            end else begin
              err_valid <= 1'b1;
              err_code  <= 2'b10;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hid_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_hid_cmd_parser
//
// Self-checking bench for hid_cmd_parser. The timeout is shortened to
// 50 cycles. A frame-level reference model gives the expected outputs for
// every cycle. It collects the bytes that follow a SYNC in a queue and
// decides each frame from its length and XOR sum. The bench runs directed
// scenarios and then a randomized frame stream.
// -----------------------------------------------------------------------------
module tb_hid_cmd_parser;

  localparam int TC = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        drop;

  hid_cmd_parser #(
    .CLK_FREQ   (50000000),
    .TIMEOUT_US (1),
    .SYNC_BYTE  (8'hAA),
    .MAX_LEN    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_in;
  logic [7:0]  m_buf[$];
  int          m_quiet;
  logic        e_valid, e_err, e_drop;
  logic [7:0]  e_op;
  logic [2:0]  e_len;
  logic [31:0] e_pay;
  logic [1:0]  e_code;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_buf.delete(); m_quiet = 0;
    e_valid = 0; e_err = 0; e_drop = 0;
    e_op = 0; e_len = 0; e_pay = 0; e_code = 0;
  endtask

  // This task gives the outputs expected after the next rising edge.
  // v, b and rdy are the inputs applied during that cycle.
  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy);
    logic       commit;
    logic [7:0] x, l;
    int         n;
    commit = 0; e_err = 0; e_drop = 0;
    if (v) begin
      m_quiet = 0;
      if (!m_in) begin
        if (b == 8'hAA) begin m_in = 1; m_buf.delete(); end
      end else begin
        m_buf.push_back(b);
        n = m_buf.size();
        l = (n >= 2) ? m_buf[1] : 8'd0;
        if (n == 2 && l > 8'd4) begin
          e_err = 1; e_code = 2'b01; m_in = 0;
        end else if (n >= 3 && n == int'(l) + 3) begin
          x = 0;
          for (int i = 0; i < n - 1; i++) x ^= m_buf[i];
          if (x == m_buf[n-1]) commit = 1;
          else begin e_err = 1; e_code = 2'b10; end
          m_in = 0;
        end
      end
    end else if (m_in) begin
      m_quiet++;
      if (m_quiet == TC) begin e_err = 1; e_code = 2'b11; m_in = 0; end
    end
    if (commit) begin
      if (!e_valid || rdy) begin
        l       = m_buf[1];
        e_valid = 1;
        e_op    = m_buf[0];
        e_len   = l[2:0];
        e_pay   = 0;
        for (int i = 0; i < int'(l); i++) e_pay[8*i +: 8] = m_buf[2+i];
      end else begin
        e_drop = 1;
      end
    end else if (e_valid && rdy) begin
      e_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("cmd_valid", {31'd0, cmd_valid}, {31'd0, e_valid});
    if (e_valid) begin
      check("cmd_op", {24'd0, cmd_op}, {24'd0, e_op});
      check("cmd_len", {29'd0, cmd_len}, {29'd0, e_len});
      check("cmd_payload", cmd_payload, e_pay);
    end
    check("err_valid", {31'd0, err_valid}, {31'd0, e_err});
    check("err_code", {30'd0, err_code}, {30'd0, e_code});
    check("drop", {31'd0, drop}, {31'd0, e_drop});
  endtask

  // The bench enters this task 1 time unit after a rising edge. It applies
  // the inputs for one cycle and then samples 1 time unit after the next edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    rx_valid = v; rx_byte = v ? b : 8'h00; cmd_ready = rdy;
    model_step(v, b, rdy);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    check({tag, "_cmd_op"}, {24'd0, cmd_op}, 32'd0);
    check({tag, "_cmd_len"}, {29'd0, cmd_len}, 32'd0);
    check({tag, "_cmd_payload"}, cmd_payload, 32'd0);
    check({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
    check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
    check({tag, "_drop"}, {31'd0, drop}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         to_seen;
    int         len, kind, cut, nb;
    logic [7:0] fr[$];
    logic [7:0] x;

    reset = 1'b0; rx_valid = 0; rx_byte = 0; cmd_ready = 0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Normal frame. The command is held while ready stays low.
    send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h34, 0); send(8'h56, 0); send(8'h70, 0);
    check("norm_valid", {31'd0, cmd_valid}, 32'd1);
    check("norm_op", {24'd0, cmd_op}, 32'h10);
    check("norm_len", {29'd0, cmd_len}, 32'd2);
    check("norm_pay", cmd_payload, 32'h0000_5634);
    idle(5, 0);
    check("norm_hold_pay", cmd_payload, 32'h0000_5634);
    step(0, 8'h00, 1);
    check("norm_consumed", {31'd0, cmd_valid}, 32'd0);

    // Leading noise, then a zero-length frame.
    send(8'h00, 0); send(8'hFF, 0); send(8'hAA, 0);
    send(8'h05, 0); send(8'h00, 0); send(8'h05, 0);
    check("zl_op", {24'd0, cmd_op}, 32'h05);
    check("zl_len", {29'd0, cmd_len}, 32'd0);
    check("zl_pay", cmd_payload, 32'd0);
    step(0, 8'h00, 1);

    // Error: length over MAX_LEN.
    send(8'hAA, 0); send(8'h01, 0); send(8'h05, 0);
    check("len_err_v", {31'd0, err_valid}, 32'd1);
    check("len_err_c", {30'd0, err_code}, 32'd1);
    idle(2, 0);

    // Error: checksum mismatch.
    send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h34, 0); send(8'h56, 0); send(8'h71, 0);
    check("cs_err_v", {31'd0, err_valid}, 32'd1);
    check("cs_err_c", {30'd0, err_code}, 32'd2);
    check("cs_no_cmd", {31'd0, cmd_valid}, 32'd0);
    idle(2, 0);

    // Timeout. The strobe appears 50 cycles after the last byte.
    send(8'hAA, 0); send(8'h10, 0);
    to_seen = -1;
    for (int k = 1; k <= 60; k++) begin
      step(0, 8'h00, 0);
      if (err_valid && to_seen < 0) to_seen = k;
    end
    check("to_latency", to_seen, TC);
    check("to_code", {30'd0, err_code}, 32'd3);
    send(8'hAA, 0); send(8'h05, 0); send(8'h00, 0); send(8'h05, 0);
    check("to_next_op", {24'd0, cmd_op}, 32'h05);
    step(0, 8'h00, 1);

    // A byte on the terminal-count cycle suppresses the timeout.
    send(8'hAA, 0); send(8'h10, 0);
    idle(TC - 1, 0);
    send(8'h00, 0);
    check("tc_byte_no_err", {31'd0, err_valid}, 32'd0);
    send(8'h10, 0);
    check("tc_byte_cmd", {31'd0, cmd_valid}, 32'd1);
    check("tc_byte_op", {24'd0, cmd_op}, 32'h10);
    step(0, 8'h00, 1);

    // Backpressure. The second frame is dropped while the first is held.
    send(8'hAA, 0); send(8'h01, 0); send(8'h01, 0); send(8'h11, 0); send(8'h11, 0);
    send(8'hAA, 0); send(8'h02, 0); send(8'h00, 0); send(8'h02, 0);
    check("bp_drop", {31'd0, drop}, 32'd1);
    check("bp_held_op", {24'd0, cmd_op}, 32'h01);
    step(0, 8'h00, 0);
    check("bp_drop_once", {31'd0, drop}, 32'd0);
    step(0, 8'h00, 1);
    // The second frame commits in the same cycle that the first is consumed.
    send(8'hAA, 0); send(8'h01, 0); send(8'h01, 0); send(8'h11, 0); send(8'h11, 0);
    send(8'hAA, 0); send(8'h02, 0); send(8'h00, 0); send(8'h02, 1);
    check("bp2_no_drop", {31'd0, drop}, 32'd0);
    check("bp2_valid", {31'd0, cmd_valid}, 32'd1);
    check("bp2_op", {24'd0, cmd_op}, 32'h02);
    step(0, 8'h00, 1);

    // Randomized frame stream compared against the model.
    for (int f = 0; f < 200; f++) begin
      fr.delete();
      if ($urandom_range(3) == 0) fr.push_back(8'($urandom_range(8'hA9)));
      kind = int'($urandom_range(9));
      len  = (kind == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4));
      fr.push_back(8'hAA);
      fr.push_back(8'($urandom));
      fr.push_back(8'(len));
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
      x = 0;
      for (int i = 1; i < fr.size(); i++) if (fr[i-1] == 8'hAA && i == 1) x = 0;
      for (int i = fr.size() - len - 2; i < fr.size(); i++) x ^= fr[i];
      if (kind == 1) x ^= 8'(1 << $urandom_range(7));
      fr.push_back(x);
      cut = (kind == 2) ? int'($urandom_range(fr.size() - 1, 1)) : fr.size();
      nb = 0;
      foreach (fr[i]) begin
        if (nb >= cut) break;
        send(fr[i], 1'($urandom_range(2) == 0));
        nb++;
        if ($urandom_range(3) == 0) begin
          for (int g = 0; g < int'($urandom_range(3, 1)); g++)
            step(0, 8'h00, 1'($urandom_range(2) == 0));
        end
      end
      if (kind == 2) begin
        for (int g = 0; g < TC + 3; g++) step(0, 8'h00, 1'($urandom_range(2) == 0));
      end
    end
    idle(2, 1);

    // Asynchronous reset in the middle of a payload while a command is held.
    send(8'hAA, 0); send(8'h07, 0); send(8'h00, 0); send(8'h07, 0);
    send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0); send(8'h34, 0);
    #2 reset = 1'b0; rx_valid = 0; cmd_ready = 0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    send(8'hAA, 0); send(8'h10, 0); send(8'h02, 0);
    send(8'h34, 0); send(8'h56, 0); send(8'h70, 0);
    check("post_rst_op", {24'd0, cmd_op}, 32'h10);
    check("post_rst_pay", cmd_payload, 32'h0000_5634);
    step(0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
